// File: rtl/usb_rx_pkt_pkg.sv
// Shared PID encodings, FSM states and CRC constants for the USB receive packet path.
package usb_rx_pkt_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SOF   = 4'b0101,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_DATA2 = 4'b0111,
        PID_MDATA = 4'b1111,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110,
        PID_NYET  = 4'b0110
    } pid_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_TOK1,
        ST_TOK2,
        ST_DATA,
        ST_HS,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // PID[1:0] alone identifies the packet class.
    localparam logic [1:0] PTYPE_TOKEN = 2'b01;
    localparam logic [1:0] PTYPE_DATA  = 2'b11;
    localparam logic [1:0] PTYPE_HS    = 2'b10;

    localparam logic [4:0]  CRC5_INIT      = 5'h1F;
    localparam logic [4:0]  CRC5_POLY      = 5'b00101;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
        logic [4:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = {c[3:0], 1'b0} ^ ((c[4] ^ data[i]) ? CRC5_POLY : 5'b00000);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 (LSB-first bit order); used by usb_rx_pkt when USB_RX_CRC16_EN is defined.
module usb_crc16
    import usb_rx_pkt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        for (int i = 0; i < 8; i++) begin
            crc_d = {crc_d[14:0], 1'b0} ^ ((crc_d[15] ^ data_i[i]) ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            crc_q <= CRC16_INIT;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/usb_rx_pkt.sv
// USB receive packet controller: PID decode, CRC5/CRC16 check, address match, payload streaming.
// Define USB_RX_CRC16_EN to check the DATA packet CRC16; otherwise CRC bytes are only stripped.
module usb_rx_pkt
    import usb_rx_pkt_pkg::*;
#(
    parameter int MAX_PKT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] dev_addr,
    input  logic [7:0] rx_data,
    input  logic       rx_active,
    input  logic       rx_valid,
    input  logic       rx_error,
    output logic       tok_valid,
    output logic [3:0] tok_pid,
    output logic [3:0] tok_endp,
    output logic [6:0] tok_addr,
    output logic       hs_valid,
    output logic [7:0] pd_data,
    output logic       pd_valid,
    output logic       pkt_done,
    output logic [3:0] pkt_pid,
    output logic [3:0] pkt_err
);

    localparam int CNT_W = $clog2(MAX_PKT + 4);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_OVF = CNT_W'(MAX_PKT + 2);

    state_t           state_q;
    logic [3:0]       err_q;
    logic [3:0]       pid_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       crc5_q;
    logic [7:0]       tok0_q, tok1_q;
    logic [7:0]       dly0_q, dly1_q;
    logic             act_prev_q;

    logic             tok_valid_q, hs_valid_q, pd_valid_q, pkt_done_q;
    logic [3:0]       tok_pid_q, tok_endp_q, pkt_pid_q, pkt_err_q;
    logic [6:0]       tok_addr_q;
    logic [7:0]       pd_data_q;

    logic             data_crc_bad;
    logic             end_crc_err;
    logic             end_pid_err;

`ifdef USB_RX_CRC16_EN
    logic [15:0] crc16;
    logic        crc16_clr;
    logic        crc16_en;

    assign crc16_clr = (state_q == ST_IDLE);
    assign crc16_en  = (state_q == ST_DATA) && rx_active && rx_valid && !rx_error;

    usb_crc16 u_crc16 (
        .clk     (clk),
        .reset   (reset),
        .clear_i (crc16_clr),
        .en_i    (crc16_en),
        .data_i  (rx_data),
        .crc_o   (crc16)
    );

    assign data_crc_bad = (crc16 != CRC16_RESIDUAL);
`else
    assign data_crc_bad = 1'b0;
`endif

    // Errors that can only be judged once rx_active has dropped.
    always_comb begin
        end_crc_err = 1'b0;
        end_pid_err = 1'b0;
        case (state_q)
            ST_PID:           end_pid_err = 1'b1;
            ST_TOK1, ST_TOK2: end_crc_err = (cnt_q != CNT_TWO) || (crc5_q != CRC5_RESIDUAL);
            ST_DATA:          end_crc_err = (cnt_q < CNT_TWO) || data_crc_bad;
            default:          ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            err_q       <= 4'b0000;
            pid_q       <= 4'b0000;
            cnt_q       <= '0;
            crc5_q      <= CRC5_INIT;
            tok0_q      <= 8'h00;
            tok1_q      <= 8'h00;
            dly0_q      <= 8'h00;
            dly1_q      <= 8'h00;
            act_prev_q  <= 1'b1;
            tok_valid_q <= 1'b0;
            tok_pid_q   <= 4'b0000;
            tok_endp_q  <= 4'b0000;
            tok_addr_q  <= 7'h00;
            hs_valid_q  <= 1'b0;
            pd_data_q   <= 8'h00;
            pd_valid_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_pid_q   <= 4'b0000;
            pkt_err_q   <= 4'b0000;
        end else begin
            act_prev_q  <= rx_active;
            tok_valid_q <= 1'b0;
            hs_valid_q  <= 1'b0;
            pd_valid_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
            case (state_q)
                // Only a fresh rising edge starts a packet, so a reset mid-packet skips its tail.
                ST_IDLE: begin
                    if (rx_active && !act_prev_q) begin
                        state_q <= ST_PID;
                        err_q   <= 4'b0000;
                        pid_q   <= 4'b0000;
                        cnt_q   <= '0;
                        crc5_q  <= CRC5_INIT;
                    end
                end
                ST_DONE: begin
                    pkt_done_q <= 1'b1;
                    pkt_pid_q  <= pid_q;
                    pkt_err_q  <= err_q;
                    if (err_q == 4'b0000 && pid_q[1:0] == PTYPE_TOKEN &&
                        (tok0_q[6:0] == dev_addr || pid_q == PID_SOF)) begin
                        tok_valid_q <= 1'b1;
                        tok_pid_q   <= pid_q;
                        tok_endp_q  <= {tok1_q[2:0], tok0_q[7]};
                        tok_addr_q  <= tok0_q[6:0];
                    end
                    if (err_q == 4'b0000 && pid_q[1:0] == PTYPE_HS) begin
                        hs_valid_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    if (!rx_active) begin
                        err_q   <= err_q | {1'b0, end_crc_err, end_pid_err, rx_error};
                        state_q <= ST_DONE;
                    end else if (rx_error) begin
                        err_q[0] <= 1'b1;
                        state_q  <= ST_DRAIN;
                    end else if (rx_valid) begin
                        case (state_q)
                            ST_PID: begin
                                pid_q <= rx_data[3:0];
                                if (rx_data[7:4] != ~rx_data[3:0]) begin
                                    err_q[1] <= 1'b1;
                                    state_q  <= ST_DRAIN;
                                end else begin
                                    case (rx_data[1:0])
                                        PTYPE_TOKEN: state_q <= ST_TOK1;
                                        PTYPE_DATA:  state_q <= ST_DATA;
                                        PTYPE_HS:    state_q <= ST_HS;
                                        default:     state_q <= ST_DRAIN;
                                    endcase
                                end
                            end
                            ST_TOK1: begin
                                tok0_q  <= rx_data;
                                crc5_q  <= crc5_byte(crc5_q, rx_data);
                                cnt_q   <= cnt_q + CNT_ONE;
                                state_q <= ST_TOK2;
                            end
                            ST_TOK2: begin
                                if (cnt_q == CNT_TWO) begin
                                    err_q[1] <= 1'b1;
                                    state_q  <= ST_DRAIN;
                                end else begin
                                    tok1_q <= rx_data;
                                    crc5_q <= crc5_byte(crc5_q, rx_data);
                                    cnt_q  <= cnt_q + CNT_ONE;
                                end
                            end
                            // Two-byte delay line holds back the trailing CRC bytes.
                            ST_DATA: begin
                                cnt_q  <= cnt_q + CNT_ONE;
                                dly0_q <= rx_data;
                                dly1_q <= dly0_q;
                                if (cnt_q >= CNT_TWO) begin
                                    pd_valid_q <= 1'b1;
                                    pd_data_q  <= dly1_q;
                                end
                                if (cnt_q >= CNT_OVF) begin
                                    err_q[3] <= 1'b1;
                                    state_q  <= ST_DRAIN;
                                end
                            end
                            ST_HS: begin
                                err_q[1] <= 1'b1;
                                state_q  <= ST_DRAIN;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign tok_valid = tok_valid_q;
    assign tok_pid   = tok_pid_q;
    assign tok_endp  = tok_endp_q;
    assign tok_addr  = tok_addr_q;
    assign hs_valid  = hs_valid_q;
    assign pd_data   = pd_data_q;
    assign pd_valid  = pd_valid_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_pid   = pkt_pid_q;
    assign pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_usb_rx_pkt.sv
// Directed self-checking bench for usb_rx_pkt; expectations follow USB_RX_CRC16_EN when defined.
`timescale 1ns/1ps
module tb_usb_rx_pkt;

    localparam int MAX_PKT = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] dev_addr = 7'h05;
    logic [7:0] rx_data = 8'h00;
    logic       rx_active = 1'b0;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic       tok_valid, hs_valid, pd_valid, pkt_done;
    logic [3:0] tok_pid, tok_endp, pkt_pid, pkt_err;
    logic [6:0] tok_addr;
    logic [7:0] pd_data;

    int total = 0;
    int bad = 0;
    logic [7:0] pd_log[$];
    int done_seen = 0;

    usb_rx_pkt #(.MAX_PKT(MAX_PKT)) dut (
        .clk       (clk),
        .reset     (reset),
        .dev_addr  (dev_addr),
        .rx_data   (rx_data),
        .rx_active (rx_active),
        .rx_valid  (rx_valid),
        .rx_error  (rx_error),
        .tok_valid (tok_valid),
        .tok_pid   (tok_pid),
        .tok_endp  (tok_endp),
        .tok_addr  (tok_addr),
        .hs_valid  (hs_valid),
        .pd_data   (pd_data),
        .pd_valid  (pd_valid),
        .pkt_done  (pkt_done),
        .pkt_pid   (pkt_pid),
        .pkt_err   (pkt_err)
    );

    always #21 clk = ~clk;

    // Payload strobes and packet completions are logged for the tests to inspect.
    always @(negedge clk) begin
        if (pd_valid) pd_log.push_back(pd_data);
        if (pkt_done) done_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_pkt();
        rx_active = 1'b1;
        tick(2);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tick(1);
    endtask

    // Leaves the bench on the negedge where pkt_done is expected to be high.
    task automatic end_pkt();
        rx_active = 1'b0;
        tick(2);
    endtask

    function automatic logic [15:0] make_token(input logic [6:0] addr, input logic [3:0] endp);
        logic [10:0] d;
        logic [4:0]  c;
        logic [15:0] t;
        logic        fb;
        d = {endp, addr};
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            fb = c[4] ^ d[i];
            c = {c[3:0], 1'b0};
            if (fb) c = c ^ 5'b00101;
        end
        t[10:0] = d;
        for (int j = 0; j < 5; j++) t[11+j] = ~c[4-j];
        return t;
    endfunction

    task automatic send_data(input logic [7:0] pid_byte, input int n, input logic corrupt);
        logic [15:0] c;
        logic [7:0]  b, c0, c1;
        logic        fb;
        c = 16'hFFFF;
        send_byte(pid_byte);
        for (int i = 0; i < n; i++) begin
            b = 8'(i);
            for (int k = 0; k < 8; k++) begin
                fb = c[15] ^ b[k];
                c = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
            send_byte(b);
        end
        for (int j = 0; j < 8; j++) begin
            c0[j] = ~c[15-j];
            c1[j] = ~c[7-j];
        end
        if (corrupt) c1 = c1 ^ 8'h01;
        send_byte(c0);
        send_byte(c1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        total++; if (pkt_done !== 1'b0) begin bad++; $display("[TB] FAIL reset.pkt_done got=%0b want=0", pkt_done); end
        total++; if (tok_valid !== 1'b0 || hs_valid !== 1'b0 || pd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset.strobes got=%0b%0b%0b want=000", tok_valid, hs_valid, pd_valid); end
        total++; if ({pkt_pid, pkt_err, pd_data} !== 16'h0000) begin bad++; $display("[TB] FAIL reset.fields got=%h want=0000", {pkt_pid, pkt_err, pd_data}); end
        total++; if ({tok_pid, tok_endp, tok_addr} !== 15'h0000) begin bad++; $display("[TB] FAIL reset.tok got=%h want=0000", {tok_pid, tok_endp, tok_addr}); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_setup_known();
        dev_addr = 7'h00;
        start_pkt();
        send_byte(8'h2D);
        send_byte(8'h00);
        send_byte(8'h10);
        end_pkt();
        total++; if (tok_valid !== 1'b1) begin bad++; $display("[TB] FAIL setup.tok_valid got=%0b want=1", tok_valid); end
        total++; if (tok_pid !== 4'hD || pkt_err !== 4'h0) begin bad++; $display("[TB] FAIL setup.pid_err got=%h/%h want=d/0", tok_pid, pkt_err); end
        tick(2);
    endtask

    task automatic test_token_match();
        logic [15:0] t;
        t = make_token(7'h05, 4'h1);
        dev_addr = 7'h05;
        start_pkt();
        send_byte(8'h69);
        send_byte(t[7:0]);
        send_byte(t[15:8]);
        rx_active = 1'b0;
        tick(1);
        total++; if (pkt_done !== 1'b0 || tok_valid !== 1'b0) begin bad++; $display("[TB] FAIL match.early got=%0b%0b want=00", pkt_done, tok_valid); end
        tick(1);
        total++; if (pkt_done !== 1'b1) begin bad++; $display("[TB] FAIL match.pkt_done got=%0b want=1", pkt_done); end
        total++; if (tok_valid !== 1'b1) begin bad++; $display("[TB] FAIL match.tok_valid got=%0b want=1", tok_valid); end
        total++; if (tok_pid !== 4'b1001 || tok_endp !== 4'h1 || tok_addr !== 7'h05) begin bad++; $display("[TB] FAIL match.fields got=%h/%h/%h want=9/1/05", tok_pid, tok_endp, tok_addr); end
        total++; if (pkt_err !== 4'h0 || pkt_pid !== 4'h9) begin bad++; $display("[TB] FAIL match.status got=%h/%h want=0/9", pkt_err, pkt_pid); end
        tick(1);
        total++; if (pkt_done !== 1'b0 || tok_valid !== 1'b0) begin bad++; $display("[TB] FAIL match.pulse_width got=%0b%0b want=00", pkt_done, tok_valid); end
        tick(2);
    endtask

    task automatic test_token_mismatch();
        logic [15:0] t;
        t = make_token(7'h05, 4'h1);
        dev_addr = 7'h06;
        start_pkt();
        send_byte(8'h69);
        send_byte(t[7:0]);
        send_byte(t[15:8]);
        end_pkt();
        total++; if (pkt_done !== 1'b1 || pkt_err !== 4'h0) begin bad++; $display("[TB] FAIL mismatch.done got=%0b/%h want=1/0", pkt_done, pkt_err); end
        total++; if (tok_valid !== 1'b0) begin bad++; $display("[TB] FAIL mismatch.tok_valid got=%0b want=0", tok_valid); end
        tick(2);
    endtask

    task automatic test_token_crc_err();
        logic [15:0] t;
        t = make_token(7'h05, 4'h1);
        t[15] = ~t[15];
        dev_addr = 7'h05;
        start_pkt();
        send_byte(8'h69);
        send_byte(t[7:0]);
        send_byte(t[15:8]);
        end_pkt();
        total++; if (pkt_err !== 4'b0100) begin bad++; $display("[TB] FAIL crc5.pkt_err got=%b want=0100", pkt_err); end
        total++; if (tok_valid !== 1'b0) begin bad++; $display("[TB] FAIL crc5.tok_valid got=%0b want=0", tok_valid); end
        tick(2);
    endtask

    task automatic test_sof();
        logic [15:0] t;
        t = make_token(7'h23, 4'h9);
        dev_addr = 7'h05;
        start_pkt();
        send_byte(8'hA5);
        send_byte(t[7:0]);
        send_byte(t[15:8]);
        end_pkt();
        total++; if (tok_valid !== 1'b1) begin bad++; $display("[TB] FAIL sof.tok_valid got=%0b want=1", tok_valid); end
        total++; if (tok_pid !== 4'h5 || tok_endp !== 4'h9 || tok_addr !== 7'h23) begin bad++; $display("[TB] FAIL sof.frame got=%h/%h/%h want=5/9/23", tok_pid, tok_endp, tok_addr); end
        tick(2);
    endtask

    task automatic test_data_good();
        int s;
        #1 s = pd_log.size();
        start_pkt();
        send_data(8'hC3, 4, 1'b0);
        end_pkt();
        total++; if (pkt_done !== 1'b1 || pkt_err !== 4'h0 || pkt_pid !== 4'h3) begin bad++; $display("[TB] FAIL data.status got=%0b/%h/%h want=1/0/3", pkt_done, pkt_err, pkt_pid); end
        #1;
        total++; if (pd_log.size() - s !== 4) begin bad++; $display("[TB] FAIL data.count got=%0d want=4", pd_log.size() - s); end
        for (int i = 0; i < 4; i++) begin
            total++; if (s + i < pd_log.size() && pd_log[s+i] !== 8'(i)) begin bad++; $display("[TB] FAIL data.byte%0d got=%h want=%h", i, pd_log[s+i], 8'(i)); end
        end
        tick(2);
    endtask

    task automatic test_data_bad_crc();
        int s;
        logic [3:0] exp_err;
`ifdef USB_RX_CRC16_EN
        exp_err = 4'b0100;
`else
        exp_err = 4'b0000;
`endif
        #1 s = pd_log.size();
        start_pkt();
        send_data(8'hC3, 4, 1'b1);
        end_pkt();
        total++; if (pkt_err !== exp_err) begin bad++; $display("[TB] FAIL badcrc.pkt_err got=%b want=%b", pkt_err, exp_err); end
        #1;
        total++; if (pd_log.size() - s !== 4) begin bad++; $display("[TB] FAIL badcrc.count got=%0d want=4", pd_log.size() - s); end
        tick(2);
    endtask

    task automatic test_data_short();
        int s;
        #1 s = pd_log.size();
        start_pkt();
        send_byte(8'h4B);
        send_byte(8'h77);
        end_pkt();
        total++; if (pkt_err !== 4'b0100) begin bad++; $display("[TB] FAIL short.pkt_err got=%b want=0100", pkt_err); end
        #1;
        total++; if (pd_log.size() - s !== 0) begin bad++; $display("[TB] FAIL short.count got=%0d want=0", pd_log.size() - s); end
        tick(2);
    endtask

    task automatic test_overflow();
        int s;
        #1 s = pd_log.size();
        start_pkt();
        send_data(8'h4B, MAX_PKT + 3, 1'b0);
        end_pkt();
        total++; if (pkt_err !== 4'b1000 || pkt_pid !== 4'hB) begin bad++; $display("[TB] FAIL ovf.status got=%b/%h want=1000/b", pkt_err, pkt_pid); end
        #1;
        total++; if (pd_log.size() - s !== MAX_PKT + 1) begin bad++; $display("[TB] FAIL ovf.count got=%0d want=%0d", pd_log.size() - s, MAX_PKT + 1); end
        total++; if (pd_log.size() > 0 && pd_log[pd_log.size()-1] !== 8'(MAX_PKT)) begin bad++; $display("[TB] FAIL ovf.last got=%h want=%h", pd_log[pd_log.size()-1], 8'(MAX_PKT)); end
        tick(2);
    endtask

    task automatic test_reset_mid();
        int s, d;
        start_pkt();
        send_byte(8'hC3);
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
        rx_data = 8'h55;
        rx_valid = 1'b1;
        reset = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        total++; if (pd_valid !== 1'b0 || pkt_done !== 1'b0) begin bad++; $display("[TB] FAIL rstmid.strobes got=%0b%0b want=00", pd_valid, pkt_done); end
        total++; if ({pkt_pid, pkt_err} !== 8'h00 || {tok_pid, tok_endp, tok_addr} !== 15'h0000) begin bad++; $display("[TB] FAIL rstmid.fields got=%h/%h want=00/0000", {pkt_pid, pkt_err}, {tok_pid, tok_endp, tok_addr}); end
        tick(1);
        reset = 1'b0;
        #1 s = pd_log.size();
        d = done_seen;
        send_byte(8'h56);
        send_byte(8'h57);
        send_byte(8'h58);
        rx_active = 1'b0;
        tick(4);
        #1;
        total++; if (done_seen !== d) begin bad++; $display("[TB] FAIL rstmid.no_done got=%0d want=%0d", done_seen, d); end
        total++; if (pd_log.size() !== s) begin bad++; $display("[TB] FAIL rstmid.no_pd got=%0d want=%0d", pd_log.size(), s); end
        tick(2);
    endtask

    task automatic test_handshake();
        start_pkt();
        send_byte(8'hD2);
        end_pkt();
        total++; if (hs_valid !== 1'b1) begin bad++; $display("[TB] FAIL ack.hs_valid got=%0b want=1", hs_valid); end
        total++; if (pkt_pid !== 4'h2 || pkt_err !== 4'h0) begin bad++; $display("[TB] FAIL ack.status got=%h/%h want=2/0", pkt_pid, pkt_err); end
        tick(2);
    endtask

    task automatic test_bad_pid();
        start_pkt();
        send_byte(8'hD3);
        end_pkt();
        total++; if (pkt_err !== 4'b0010) begin bad++; $display("[TB] FAIL badpid.pkt_err got=%b want=0010", pkt_err); end
        total++; if (hs_valid !== 1'b0 || tok_valid !== 1'b0) begin bad++; $display("[TB] FAIL badpid.strobes got=%0b%0b want=00", hs_valid, tok_valid); end
        tick(2);
    endtask

    task automatic test_hs_extra();
        start_pkt();
        send_byte(8'hD2);
        send_byte(8'h00);
        end_pkt();
        total++; if (pkt_err !== 4'b0010 || hs_valid !== 1'b0) begin bad++; $display("[TB] FAIL hsextra got=%b/%0b want=0010/0", pkt_err, hs_valid); end
        tick(2);
    endtask

    task automatic test_rx_error();
        int s0, s1;
        #1 s0 = pd_log.size();
        start_pkt();
        send_byte(8'hC3);
        send_byte(8'h10);
        send_byte(8'h11);
        send_byte(8'h12);
        #1 s1 = pd_log.size();
        rx_data = 8'h13;
        rx_valid = 1'b1;
        rx_error = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_error = 1'b0;
        tick(1);
        send_byte(8'h14);
        send_byte(8'h15);
        end_pkt();
        total++; if (pkt_err[0] !== 1'b1) begin bad++; $display("[TB] FAIL rxerr.pkt_err got=%b want=xxx1", pkt_err); end
        #1;
        total++; if (pd_log.size() !== s1) begin bad++; $display("[TB] FAIL rxerr.after got=%0d want=0", pd_log.size() - s1); end
        total++; if (s1 - s0 !== 1) begin bad++; $display("[TB] FAIL rxerr.before got=%0d want=1", s1 - s0); end
        tick(2);
    endtask

    task automatic test_empty();
        start_pkt();
        end_pkt();
        total++; if (pkt_done !== 1'b1 || pkt_pid !== 4'h0 || pkt_err !== 4'b0010) begin bad++; $display("[TB] FAIL empty got=%0b/%h/%b want=1/0/0010", pkt_done, pkt_pid, pkt_err); end
        tick(2);
    endtask

    task automatic test_back_to_back();
        logic [15:0] t;
        t = make_token(7'h11, 4'h3);
        dev_addr = 7'h11;
        start_pkt();
        send_byte(8'hD2);
        end_pkt();
        total++; if (hs_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b.hs_valid got=%0b want=1", hs_valid); end
        start_pkt();
        send_byte(8'hE1);
        send_byte(t[7:0]);
        send_byte(t[15:8]);
        end_pkt();
        total++; if (tok_valid !== 1'b1 || tok_pid !== 4'h1 || tok_endp !== 4'h3 || tok_addr !== 7'h11) begin bad++; $display("[TB] FAIL b2b.tok got=%0b/%h/%h/%h want=1/1/3/11", tok_valid, tok_pid, tok_endp, tok_addr); end
        tick(2);
    endtask

    initial begin
        test_reset();
        test_setup_known();
        test_token_match();
        test_token_mismatch();
        test_token_crc_err();
        test_sof();
        test_data_good();
        test_data_bad_crc();
        test_data_short();
        test_overflow();
        test_reset_mid();
        test_handshake();
        test_bad_pid();
        test_hs_extra();
        test_rx_error();
        test_empty();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
